// File: rtl/dyn_add_ctrl.sv
// dyn_add_ctrl: shares one variable-latency adder and its stopwatch between
// NREQ requesters. A round-robin arbiter picks a requester in IDLE, the
// operands are latched and presented to the adder, the stopwatch is released
// for the RUN phase, and the result is returned on a valid/ready port.
// Optional feature macro: DYN_ADD_CTRL_TIMEOUT_EN (aborts RUN after TMAX
// cycles without add_done and reports rsp_timeout=1).
module dyn_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2,
    parameter int CW    = 3,
    parameter int TMAX  = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     a_in,
    input  logic [NREQ*WIDTH-1:0]     b_in,
    output logic [NREQ-1:0]           gnt,
    output logic [WIDTH-1:0]          add_a,
    output logic [WIDTH-1:0]          add_b,
    output logic                      first,
    input  logic                      add_done,
    input  logic [WIDTH:0]            add_sum,
    input  logic [CW-1:0]             sw_count,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [WIDTH:0]            rsp_sum,
    output logic [CW-1:0]             rsp_lat,
    output logic [CW-1:0]             rsp_sw,
    output logic                      rsp_timeout
);

    localparam int IDW  = $clog2(NREQ);
    localparam int IDW1 = IDW + 1;
    localparam logic [CW-1:0] CMAX = {CW{1'b1}};

`ifdef DYN_ADD_CTRL_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_RUN    = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [IDW-1:0]      r_ptr;
    logic [IDW-1:0]      r_id;
    logic [CW-1:0]       r_cnt;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH:0]      r_sum;
    logic [CW-1:0]       r_lat;
    logic [CW-1:0]       r_sw;
    logic                r_timeout;

    logic                w_found;
    logic [IDW-1:0]      w_win;
    logic [IDW-1:0]      w_ptr_next;
    logic [CW-1:0]       w_cnt_inc;
    logic                w_timeout;

    logic [WIDTH-1:0]    w_a_arr [NREQ];
    logic [WIDTH-1:0]    w_b_arr [NREQ];

    // Unpack the flat operand buses and decode the one-hot grant pulse,
    // which is only visible during LAUNCH.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign w_a_arr[gi] = a_in[gi*WIDTH +: WIDTH];
            assign w_b_arr[gi] = b_in[gi*WIDTH +: WIDTH];
            assign gnt[gi]     = (r_state == S_LAUNCH) && (r_id == IDW'(gi));
        end
    endgenerate

    // Round-robin search: first requester at or after the pointer, wrapping.
    always_comb begin
        logic [IDW1-1:0] cand_w;
        w_found = 1'b0;
        w_win   = '0;
        cand_w  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_w = {1'b0, r_ptr} + IDW1'(k);
            if (cand_w >= IDW1'(NREQ)) begin
                cand_w = cand_w - IDW1'(NREQ);
            end
            if (!w_found && req[cand_w[IDW-1:0]]) begin
                w_found = 1'b1;
                w_win   = cand_w[IDW-1:0];
            end
        end
    end

    assign w_ptr_next = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;

    // Saturating latency count and optional timeout detection.
    assign w_cnt_inc = (r_cnt == CMAX) ? CMAX : r_cnt + 1'b1;
    assign w_timeout = TO_EN && (w_cnt_inc == CW'(TMAX));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        w_state_next = r_state;
        first        = 1'b1;
        rsp_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_state_next = S_RUN;
            end
            S_RUN: begin
                first = 1'b0;
                if (add_done || w_timeout) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: operand latch on grant, latency counter, result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr     <= '0;
            r_id      <= '0;
            r_cnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_sum     <= '0;
            r_lat     <= '0;
            r_sw      <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_a   <= w_a_arr[w_win];
                        r_b   <= w_b_arr[w_win];
                        r_id  <= w_win;
                        r_ptr <= w_ptr_next;
                    end
                end
                S_LAUNCH: begin
                    r_cnt <= '0;
                end
                S_RUN: begin
                    r_cnt <= w_cnt_inc;
                    if (add_done) begin
                        // Completion takes priority over a coincident timeout.
                        r_sum     <= add_sum;
                        r_sw      <= sw_count;
                        r_lat     <= w_cnt_inc;
                        r_timeout <= 1'b0;
                    end else if (w_timeout) begin
                        r_sum     <= '0;
                        r_sw      <= sw_count;
                        r_lat     <= w_cnt_inc;
                        r_timeout <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign add_a       = r_a;
    assign add_b       = r_b;
    assign rsp_id      = r_id;
    assign rsp_sum     = r_sum;
    assign rsp_lat     = r_lat;
    assign rsp_sw      = r_sw;
    assign rsp_timeout = r_timeout;

endmodule

// File: tb/tb_dyn_add_ctrl.sv
// tb_dyn_add_ctrl: directed bench for dyn_add_ctrl. The bench plays the adder
// and stopwatch, pushes the expected response into a scoreboard queue when an
// operation is launched, and pops/compares it when rsp_valid appears.
module tb_dyn_add_ctrl;

    localparam int WIDTH = 8;
    localparam int NREQ  = 2;
    localparam int CW    = 3;
    localparam int TMAX  = 6;

`ifdef DYN_ADD_CTRL_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_in;
    logic [NREQ*WIDTH-1:0] b_in;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      add_a;
    logic [WIDTH-1:0]      add_b;
    logic                  first;
    logic                  add_done;
    logic [WIDTH:0]        add_sum;
    logic [CW-1:0]         sw_count;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [0:0]            rsp_id;
    logic [WIDTH:0]        rsp_sum;
    logic [CW-1:0]         rsp_lat;
    logic [CW-1:0]         rsp_sw;
    logic                  rsp_timeout;

    typedef struct {
        logic [0:0]    id;
        logic [WIDTH:0] sum;
        logic [CW-1:0] lat;
        logic [CW-1:0] sw;
        logic          to;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] op_a [NREQ];
    logic [WIDTH-1:0] op_b [NREQ];

    dyn_add_ctrl #(
        .WIDTH(WIDTH), .NREQ(NREQ), .CW(CW), .TMAX(TMAX)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .add_a(add_a), .add_b(add_b), .first(first),
        .add_done(add_done), .add_sum(add_sum), .sw_count(sw_count),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_lat(rsp_lat), .rsp_sw(rsp_sw),
        .rsp_timeout(rsp_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] sw_pat(input int k);
        return CW'(k * 3 + 1);
    endfunction

    task automatic drive_ops();
        a_in = {op_a[1], op_a[0]};
        b_in = {op_b[1], op_b[0]};
    endtask

    // One complete operation starting from IDLE (called #1 after an edge).
    // done_cyc = RUN cycle in which add_done is driven (0 = never).
    task automatic run_op(input logic [1:0] req_v, input logic [1:0] req_hold,
                          input int exp_id, input int done_cyc, input int ready_wait);
        exp_t e;
        exp_t got;
        int k_end;
        logic [WIDTH:0] s;
        logic [1:0] g;
        s = {1'b0, op_a[exp_id]} + {1'b0, op_b[exp_id]};
        e.id = 1'(exp_id);
        if (TO_ON && (done_cyc == 0 || done_cyc > TMAX)) begin
            k_end = TMAX;
            e.sum = '0;
            e.lat = CW'(TMAX);
            e.to  = 1'b1;
        end else begin
            k_end = done_cyc;
            e.sum = s;
            e.lat = CW'((done_cyc > 7) ? 7 : done_cyc);
            e.to  = 1'b0;
        end
        e.sw = sw_pat(k_end);
        sb_q.push_back(e);

        drive_ops();
        req = req_v;
        chk("idle_gnt", gnt, 0);
        chk("idle_first", first, 1);

        @(posedge clk); #1;
        req = req_hold;
        g = 2'b01 << exp_id;
        chk("launch_gnt", gnt, g);
        chk("launch_first", first, 1);
        chk("launch_add_a", add_a, op_a[exp_id]);
        chk("launch_add_b", add_b, op_b[exp_id]);
        // A spurious done during LAUNCH must be ignored.
        add_done = 1'b1;
        add_sum  = '1;

        @(posedge clk); #1;
        for (int k = 1; k <= k_end; k++) begin
            chk("run_valid", rsp_valid, 0);
            if (k == 1) begin
                chk("run_first", first, 0);
                chk("run_gnt", gnt, 0);
            end
            add_done = (k == done_cyc);
            add_sum  = s;
            sw_count = sw_pat(k);
            @(posedge clk); #1;
        end
        add_done = 1'b0;

        chk("resp_valid", rsp_valid, 1);
        chk("resp_first", first, 1);
        got = sb_q.pop_front();
        chk("rsp_id", rsp_id, got.id);
        chk("rsp_sum", rsp_sum, got.sum);
        chk("rsp_lat", rsp_lat, got.lat);
        chk("rsp_sw", rsp_sw, got.sw);
        chk("rsp_timeout", rsp_timeout, got.to);
        $display("op id=%0d sum=%0h lat=%0d sw=%0d to=%0d", rsp_id, rsp_sum, rsp_lat, rsp_sw, rsp_timeout);

        for (int w = 0; w < ready_wait; w++) begin
            rsp_ready = 1'b0;
            add_done  = 1'b1;
            add_sum   = '0;
            @(posedge clk); #1;
            chk("bp_valid", rsp_valid, 1);
            chk("bp_gnt", gnt, 0);
            chk("bp_sum", rsp_sum, got.sum);
            chk("bp_lat", rsp_lat, got.lat);
            chk("bp_id", rsp_id, got.id);
            chk("bp_sw", rsp_sw, got.sw);
        end
        add_done  = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("accept_valid", rsp_valid, 0);
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        a_in      = '0;
        b_in      = '0;
        add_done  = 1'b0;
        add_sum   = '0;
        sw_count  = '0;
        rsp_ready = 1'b0;

        // Reset values.
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_first", first, 1);
        chk("rst_gnt", gnt, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_add_b", add_b, 0);
        chk("rst_sum", rsp_sum, 0);
        chk("rst_lat", rsp_lat, 0);
        chk("rst_to", rsp_timeout, 0);
        rst = 1'b0;

        // Round-robin with both requests held and rsp_ready asserted at once.
        op_a[0] = 8'h21; op_b[0] = 8'h12;
        op_a[1] = 8'hF0; op_b[1] = 8'h33;
        run_op(2'b11, 2'b11, 0, 1, 0);
        run_op(2'b11, 2'b11, 1, 2, 0);
        op_a[0] = 8'h80; op_b[0] = 8'h80;
        run_op(2'b11, 2'b11, 0, 1, 0);
        run_op(2'b11, 2'b11, 1, 3, 0);

        // Single operation: 0x0F + 0x01, done on third RUN cycle.
        op_a[0] = 8'h0F; op_b[0] = 8'h01;
        run_op(2'b01, 2'b00, 0, 3, 0);

        // Backpressure with both requests pending (pointer now at 1).
        op_a[1] = 8'hAA; op_b[1] = 8'h55;
        run_op(2'b11, 2'b11, 1, 2, 5);
        req = '0;

`ifdef DYN_ADD_CTRL_TIMEOUT_EN
        // No done ever: timeout after TMAX RUN cycles.
        op_a[0] = 8'h11; op_b[0] = 8'h22;
        run_op(2'b01, 2'b00, 0, 0, 0);
        // Done coincides with the timeout cycle: done wins.
        op_a[1] = 8'h7F; op_b[1] = 8'h01;
        run_op(2'b10, 2'b00, 1, TMAX, 0);
`else
        // Long wait: latency saturates at 7.
        op_a[0] = 8'h11; op_b[0] = 8'h22;
        run_op(2'b01, 2'b00, 0, 20, 0);
        op_a[1] = 8'h7F; op_b[1] = 8'h01;
        run_op(2'b10, 2'b00, 1, 7, 0);
`endif

        // Mid-RUN reset: requester 0 launched (pointer moves to 1), then reset.
        op_a[0] = 8'h3C; op_b[0] = 8'h0C;
        drive_ops();
        req = 2'b01;
        @(posedge clk); #1;
        chk("mr_gnt", gnt, 2'b01);
        req = 2'b00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mr_first_run", first, 0);
        rst = 1'b1;
        #1;
        chk("mr_first", first, 1);
        chk("mr_gnt0", gnt, 0);
        chk("mr_valid", rsp_valid, 0);
        chk("mr_add_a", add_a, 0);
        chk("mr_add_b", add_b, 0);
        chk("mr_sum", rsp_sum, 0);
        chk("mr_lat", rsp_lat, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        // No response and no grant without a new request, even with add_done.
        for (int i = 0; i < 4; i++) begin
            add_done  = 1'b1;
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            chk("post_rst_valid", rsp_valid, 0);
            chk("post_rst_gnt", gnt, 0);
        end
        add_done  = 1'b0;
        rsp_ready = 1'b0;
        // Pointer was reset to 0, so requester 0 wins over 1.
        run_op(2'b11, 2'b00, 0, 2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
